// File: rtl/vcm_i2c_pkg.sv
// Shared types and constants for the VCM focus-driver I2C target model.
package vcm_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_MACK,
    ST_NACK_WAIT
  } state_e;

  localparam logic       I2C_WR           = 1'b0;
  localparam logic       I2C_RD           = 1'b1;
  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h0C;
  localparam int         BYTES_PER_XFER   = 2;

  // Bit-counter values used as phase markers around the 9th (ACK) clock.
  localparam logic [3:0] BIT_LAST  = 4'd7;
  localparam logic [3:0] ACK_PEND  = 4'd8;
  localparam logic [3:0] ACK_DRIVE = 4'd9;
  localparam logic [3:0] MACK_DONE = 4'd10;

  localparam logic [1:0] LAST_IDX  = 2'(BYTES_PER_XFER - 1);

  function automatic logic [1:0] next_byte_idx(input logic [1:0] idx);
    return (idx >= LAST_IDX) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic logic [7:0] read_byte(input logic [15:0] word, input logic [1:0] idx);
    return (idx == 2'd0) ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus FILT_LEN-sample glitch filter with edge strobes.
// Input-to-level latency is 2+FILT_LEN cycles; strobes coincide with the level change.
module i2c_line_filter #(
  parameter int   FILT_LEN  = 3,
  parameter logic RST_LEVEL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW       = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FILT_LEN - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Down-counter runs only while the synchronized input disagrees with the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = CNT_LOAD;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == '0) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
        fall_d  = ~sync_q[1];
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= {2{RST_LEVEL}};
      level_q <= RST_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= CNT_LOAD;
    end else begin
      sync_q  <= {sync_q[0], line_i};
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/vcm_i2c_responder.sv
// I2C target model of the VCM focus driver: 2-byte position writes and read-back.
//   state        | meaning
//   ST_IDLE      | bus free or not yet started
//   ST_ADDR      | shifting in address + R/W
//   ST_ADDR_ACK  | address matched, ACK on 9th clock
//   ST_WR_BYTE   | shifting in a write data byte
//   ST_WR_ACK    | ACK of an accepted write byte
//   ST_RD_BYTE   | shifting out a read byte from the shadow
//   ST_RD_MACK   | SDA released, sampling master ACK/NACK
//   ST_NACK_WAIT | ignoring the bus until START/STOP
module vcm_i2c_responder
  import vcm_i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int          FILT_LEN = 3,
  parameter logic [15:0] RST_DATA = 16'h0000
) (
  input  logic        CLK_50,
  input  logic        RESET,
  input  logic        SCL,
  input  logic        SDA_IN,
  output logic        SDA_OE,
  output logic [15:0] VCM_DATA,
  output logic        DATA_VALID,
  output logic        BUSY,
  output logic        ADDR_HIT
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILT_LEN(FILT_LEN), .RST_LEVEL(1'b1)) u_scl_filt (
    .clk_i(CLK_50), .rst_i(RESET), .line_i(SCL),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN), .RST_LEVEL(1'b1)) u_sda_filt (
    .clk_i(CLK_50), .rst_i(RESET), .line_i(SDA_IN),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  staging_q, staging_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] vcm_q, vcm_d;
  logic        rw_q, rw_d;
  logic        sda_oe_q, sda_oe_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        hit_q, hit_d;

  logic        start_det, stop_det, addr_match;
  logic [7:0]  byte_in;
  logic [1:0]  rd_next_idx;
  logic [7:0]  rd_next_byte;

  assign start_det    = sda_fall & scl_lvl;
  assign stop_det     = sda_rise & scl_lvl;
  assign byte_in      = {shift_q[6:0], sda_lvl};
  assign addr_match   = (shift_q[6:0] == DEV_ADDR);
  assign rd_next_idx  = next_byte_idx(byte_idx_q);
  assign rd_next_byte = read_byte(shadow_q, rd_next_idx);

  always_ff @(posedge CLK_50 or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      staging_q  <= '0;
      shadow_q   <= RST_DATA;
      vcm_q      <= RST_DATA;
      rw_q       <= I2C_WR;
      sda_oe_q   <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      staging_q  <= staging_d;
      shadow_q   <= shadow_d;
      vcm_q      <= vcm_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      hit_q      <= hit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = ST_ADDR;
    end else if (stop_det) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_ADDR:
          if (scl_rise && bit_cnt_q == BIT_LAST) state_d = addr_match ? ST_ADDR_ACK : ST_NACK_WAIT;
        ST_ADDR_ACK:
          if (scl_fall && bit_cnt_q == ACK_DRIVE) state_d = (rw_q == I2C_RD) ? ST_RD_BYTE : ST_WR_BYTE;
        ST_WR_BYTE:
          if (scl_rise && bit_cnt_q == BIT_LAST) state_d = (byte_idx_q > LAST_IDX) ? ST_NACK_WAIT : ST_WR_ACK;
        ST_WR_ACK:
          if (scl_fall && bit_cnt_q == ACK_DRIVE) state_d = ST_WR_BYTE;
        ST_RD_BYTE:
          if (scl_rise && bit_cnt_q == BIT_LAST) state_d = ST_RD_MACK;
        ST_RD_MACK:
          if (scl_rise && bit_cnt_q == ACK_DRIVE && sda_lvl) state_d = ST_NACK_WAIT;
          else if (scl_fall && bit_cnt_q == MACK_DONE) state_d = ST_RD_BYTE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    staging_d  = staging_q;
    shadow_d   = shadow_q;
    vcm_d      = vcm_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    hit_d      = hit_q;
    if (start_det || stop_det) begin
      bit_cnt_d  = '0;
      byte_idx_d = '0;
      sda_oe_d   = 1'b0;
      hit_d      = 1'b0;
      busy_d     = start_det;
    end else begin
      case (state_q)
        ST_ADDR:
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == BIT_LAST && addr_match) begin
              hit_d    = 1'b1;
              rw_d     = sda_lvl;
              shadow_d = vcm_q;
            end
          end
        ST_ADDR_ACK, ST_WR_ACK:
          if (scl_fall) begin
            if (bit_cnt_q == ACK_PEND) begin
              sda_oe_d  = 1'b1;
              bit_cnt_d = ACK_DRIVE;
            end else if (bit_cnt_q == ACK_DRIVE) begin
              bit_cnt_d = '0;
              sda_oe_d  = 1'b0;
              // A read presents its first bit on the same falling edge that ends the ACK.
              if (state_q == ST_ADDR_ACK && rw_q == I2C_RD) begin
                shift_d  = read_byte(shadow_q, 2'd0);
                sda_oe_d = ~shadow_q[15];
              end
            end
          end
        ST_WR_BYTE:
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == BIT_LAST) begin
              if (byte_idx_q < LAST_IDX) begin
                staging_d  = byte_in;
                byte_idx_d = byte_idx_q + 2'd1;
              end else if (byte_idx_q == LAST_IDX) begin
                vcm_d      = {staging_q, byte_in};
                valid_d    = 1'b1;
                byte_idx_d = byte_idx_q + 2'd1;
              end
            end
          end
        ST_RD_BYTE:
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            sda_oe_d = ~shift_q[6];
            shift_d  = {shift_q[6:0], 1'b0};
          end
        ST_RD_MACK:
          if (scl_fall && bit_cnt_q == ACK_PEND) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = ACK_DRIVE;
          end else if (scl_rise && bit_cnt_q == ACK_DRIVE) begin
            bit_cnt_d = MACK_DONE;
          end else if (scl_fall && bit_cnt_q == MACK_DONE) begin
            bit_cnt_d  = '0;
            byte_idx_d = rd_next_idx;
            shift_d    = rd_next_byte;
            sda_oe_d   = ~rd_next_byte[7];
          end
        default: ;
      endcase
    end
  end

  assign SDA_OE     = sda_oe_q;
  assign VCM_DATA   = vcm_q;
  assign DATA_VALID = valid_q;
  assign BUSY       = busy_q;
  assign ADDR_HIT   = hit_q;

endmodule

// File: tb/tb_vcm_i2c_responder.sv
// Directed bench for vcm_i2c_responder: an open-drain I2C master model plus table vectors.
module tb_vcm_i2c_responder;

  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_oe, data_valid, busy, addr_hit;
  logic [15:0] vcm_data;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int hit_cnt = 0;
  int oe_rise = 0;
  logic oe_prev = 1'b0;

  assign sda_bus = sda_m & ~sda_oe;

  always #10 clk = ~clk;

  vcm_i2c_responder #(.DEV_ADDR(7'h0C), .FILT_LEN(3), .RST_DATA(16'h0000)) dut (
    .CLK_50(clk), .RESET(rst), .SCL(scl), .SDA_IN(sda_bus),
    .SDA_OE(sda_oe), .VCM_DATA(vcm_data), .DATA_VALID(data_valid),
    .BUSY(busy), .ADDR_HIT(addr_hit)
  );

  always @(negedge clk) begin
    if (data_valid) valid_cnt <= valid_cnt + 1;
    if (addr_hit) hit_cnt <= hit_cnt + 1;
    if (sda_oe && !oe_prev) oe_rise <= oe_rise + 1;
    oe_prev <= sda_oe;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL clock: set SDA during low, sample line mid-high, optional 1-sample glitch.
  task automatic clk_bit(input logic b, input logic glitch, output logic s);
    cyc(Q); sda_m = b;
    cyc(Q); scl = 1'b1;
    cyc(Q / 2);
    if (glitch) begin sda_m = ~b; cyc(1); sda_m = b; end
    else cyc(1);
    cyc(Q / 2 - 1);
    s = sda_bus;
    cyc(Q); scl = 1'b0;
  endtask

  task automatic i2c_start;
    cyc(Q); sda_m = 1'b1;
    cyc(Q); scl = 1'b1;
    cyc(2 * Q); sda_m = 1'b0;
    cyc(2 * Q); scl = 1'b0;
  endtask

  task automatic i2c_stop;
    cyc(Q); sda_m = 1'b0;
    cyc(Q); scl = 1'b1;
    cyc(2 * Q); sda_m = 1'b1;
    cyc(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic glitch, output logic nack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], glitch, s);
    clk_bit(1'b1, 1'b0, nack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    clk_bit(mack, 1'b0, s);
  endtask

  typedef struct {
    logic [31:0] bytes;
    int          n;
    logic [3:0]  exp_nack;
    logic [15:0] exp_vcm;
    int          exp_pulses;
    int          exp_oe;
    logic        exp_hit;
  } wvec_t;

  wvec_t vec[5];

  initial begin
    logic       nack;
    logic [7:0] rd;
    int v0, h0, o0;

    vec[0] = '{32'h1803FF00, 3, 4'b0000, 16'h03FF, 1, 3, 1'b1};
    vec[1] = '{32'h1A123400, 3, 4'b0111, 16'h03FF, 0, 0, 1'b0};
    vec[2] = '{32'h18AB0000, 2, 4'b0000, 16'h03FF, 0, 2, 1'b1};
    vec[3] = '{32'h18010203, 4, 4'b1000, 16'h0102, 1, 3, 1'b1};
    vec[4] = '{32'h1803FF00, 3, 4'b0000, 16'h03FF, 1, 3, 1'b1};

    cyc(5);
    check("rst_sda_oe", {31'd0, sda_oe}, 0);
    check("rst_vcm", {16'd0, vcm_data}, 32'h0000);
    rst = 1'b0;
    cyc(10);
    check("idle_valid", {31'd0, data_valid}, 0);
    check("idle_busy", {31'd0, busy}, 0);
    check("idle_hit", {31'd0, addr_hit}, 0);

    for (int k = 0; k < 5; k++) begin
      v0 = valid_cnt; h0 = hit_cnt; o0 = oe_rise;
      i2c_start;
      check($sformatf("v%0d_busy_start", k), {31'd0, busy}, 1);
      for (int j = 0; j < vec[k].n; j++) begin
        send_byte(vec[k].bytes[31 - 8 * j -: 8], 1'b0, nack);
        check($sformatf("v%0d_ack%0d", k, j), {31'd0, nack}, {31'd0, vec[k].exp_nack[j]});
      end
      i2c_stop;
      check($sformatf("v%0d_busy_stop", k), {31'd0, busy}, 0);
      check($sformatf("v%0d_vcm", k), {16'd0, vcm_data}, {16'd0, vec[k].exp_vcm});
      check($sformatf("v%0d_pulses", k), valid_cnt - v0, vec[k].exp_pulses);
      check($sformatf("v%0d_oe_rises", k), oe_rise - o0, vec[k].exp_oe);
      check($sformatf("v%0d_hit", k), {31'd0, (hit_cnt > h0)}, {31'd0, vec[k].exp_hit});
    end

    // Write address, repeated START, read back 2 bytes.
    v0 = valid_cnt;
    i2c_start;
    send_byte(8'h18, 1'b0, nack); check("rdA_wack", {31'd0, nack}, 0);
    i2c_start;
    send_byte(8'h19, 1'b0, nack); check("rdA_rack", {31'd0, nack}, 0);
    check("rdA_hit", {31'd0, addr_hit}, 1);
    recv_byte(1'b0, rd); check("rdA_b0", {24'd0, rd}, 32'h03);
    recv_byte(1'b1, rd); check("rdA_b1", {24'd0, rd}, 32'hFF);
    i2c_stop;
    check("rdA_busy", {31'd0, busy}, 0);
    check("rdA_hit_clr", {31'd0, addr_hit}, 0);

    // Three-byte read wraps back to the MSB.
    i2c_start;
    send_byte(8'h19, 1'b0, nack); check("rdB_ack", {31'd0, nack}, 0);
    recv_byte(1'b0, rd); check("rdB_b0", {24'd0, rd}, 32'h03);
    recv_byte(1'b0, rd); check("rdB_b1", {24'd0, rd}, 32'hFF);
    recv_byte(1'b1, rd); check("rdB_b2", {24'd0, rd}, 32'h03);
    i2c_stop;
    check("rd_no_valid", valid_cnt - v0, 0);
    check("rd_vcm", {16'd0, vcm_data}, 32'h03FF);

    // Single-sample glitches on every data bit while SCL is high.
    v0 = valid_cnt;
    i2c_start;
    send_byte(8'h18, 1'b0, nack); check("gl_aack", {31'd0, nack}, 0);
    send_byte(8'h5A, 1'b1, nack); check("gl_ack0", {31'd0, nack}, 0);
    send_byte(8'hC3, 1'b1, nack); check("gl_ack1", {31'd0, nack}, 0);
    check("gl_busy", {31'd0, busy}, 1);
    check("gl_hit", {31'd0, addr_hit}, 1);
    i2c_stop;
    check("gl_vcm", {16'd0, vcm_data}, 32'h5AC3);
    check("gl_pulses", valid_cnt - v0, 1);

    // Asynchronous reset during the 5th bit of the second write byte.
    i2c_start;
    send_byte(8'h18, 1'b0, nack);
    send_byte(8'h12, 1'b0, nack); check("rs_ack0", {31'd0, nack}, 0);
    for (int i = 7; i >= 4; i--) begin
      logic s;
      clk_bit(rd[0] ^ rd[0] ^ (8'h34 >> i), 1'b0, s);
    end
    cyc(Q); sda_m = 1'b0;
    cyc(Q); scl = 1'b1;
    cyc(Q / 2);
    #3 rst = 1'b1;
    #1;
    check("rs_sda_oe", {31'd0, sda_oe}, 0);
    check("rs_vcm", {16'd0, vcm_data}, 32'h0000);
    check("rs_busy", {31'd0, busy}, 0);
    check("rs_hit", {31'd0, addr_hit}, 0);
    cyc(3);
    rst = 1'b0;
    scl = 1'b0;
    cyc(Q); sda_m = 1'b1;
    cyc(Q); scl = 1'b1;
    cyc(4 * Q);
    check("rs_vcm_after", {16'd0, vcm_data}, 32'h0000);

    v0 = valid_cnt;
    i2c_start;
    send_byte(8'h18, 1'b0, nack); check("post_aack", {31'd0, nack}, 0);
    send_byte(8'h00, 1'b0, nack); check("post_ack0", {31'd0, nack}, 0);
    send_byte(8'h80, 1'b0, nack); check("post_ack1", {31'd0, nack}, 0);
    i2c_stop;
    check("post_vcm", {16'd0, vcm_data}, 32'h0080);
    check("post_pulses", valid_cnt - v0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
